// File: rtl/data_sram_responder.sv
// Data-side SRAM responder: accepts load/store requests, commits stores at acceptance,
// and answers every transaction in order after a fixed latency through a small queue.
module data_sram_responder #(
    parameter int ADDR_WIDTH  = 12,
    parameter int LATENCY     = 2,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CD_W  = 3;
    localparam logic [CD_W-1:0]  CD_INIT = CD_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(QUEUE_DEPTH);

    logic [31:0]           mem_q [2**ADDR_WIDTH];

    logic                  ld_q   [QUEUE_DEPTH];
    logic                  ld_d   [QUEUE_DEPTH];
    logic [31:0]           word_q [QUEUE_DEPTH];
    logic [31:0]           word_d [QUEUE_DEPTH];
    logic [CD_W-1:0]       cd_q   [QUEUE_DEPTH];
    logic [CD_W-1:0]       cd_d   [QUEUE_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic [ADDR_WIDTH-1:0] idx;
    logic                  accept;
    logic                  pop;
    logic                  unused_bits;

    assign idx         = addr[ADDR_WIDTH+1:2];
    assign unused_bits = ^{size, addr[31:ADDR_WIDTH+2], addr[1:0]};

    // Full queue blocks acceptance even while the head pops: no pass-through.
    assign addr_ok = req & (count_q < CNT_MAX) & ~reset;
    assign accept  = addr_ok;
    assign pop     = (count_q != '0) && (cd_q[rd_ptr_q] == '0);
    assign data_ok = pop;
    assign rdata   = (pop && ld_q[rd_ptr_q]) ? word_q[rd_ptr_q] : 32'h0;

    always_comb begin
        logic [PTR_W-1:0] offset;
        offset   = '0;
        ld_d     = ld_q;
        word_d   = word_q;
        cd_d     = cd_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            offset = PTR_W'(i) - rd_ptr_q;
            if (({1'b0, offset} < count_q) && (cd_q[i] != '0)) begin
                cd_d[i] = cd_q[i] - 1'b1;
            end
        end

        // Stores commit at this same edge and in order, so the array read already
        // reflects every store accepted earlier.
        if (accept) begin
            ld_d[wr_ptr_q]   = ~wr;
            word_d[wr_ptr_q] = wr ? 32'h0 : mem_q[idx];
            cd_d[wr_ptr_q]   = CD_INIT;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        ld_q   <= ld_d;
        word_q <= word_d;
        cd_q   <= cd_d;
    end

    always_ff @(posedge clk) begin
        if (accept && wr) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: three instances (latency 2, 8, 3) exercised one at a
// time; a scoreboard holds expected response data and the edge each response is due.
module tb_data_sram_responder;
    logic        clk;
    logic        reset;
    logic [1:0]  size_s;
    logic        req     [3];
    logic        wr      [3];
    logic [31:0] addr    [3];
    logic [3:0]  wstrb   [3];
    logic [31:0] wdata   [3];
    logic        addr_ok [3];
    logic        data_ok [3];
    logic [31:0] rdata   [3];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          inst;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sb [$];
    exp_t        e;
    logic [31:0] mdl [3][4096];

    data_sram_responder #(.ADDR_WIDTH(12), .LATENCY(2), .QUEUE_DEPTH(4)) u_lat2 (
        .clk(clk), .reset(reset), .req(req[0]), .wr(wr[0]), .size(size_s), .addr(addr[0]),
        .wstrb(wstrb[0]), .wdata(wdata[0]), .addr_ok(addr_ok[0]), .data_ok(data_ok[0]), .rdata(rdata[0]));
    data_sram_responder #(.ADDR_WIDTH(12), .LATENCY(8), .QUEUE_DEPTH(4)) u_lat8 (
        .clk(clk), .reset(reset), .req(req[1]), .wr(wr[1]), .size(size_s), .addr(addr[1]),
        .wstrb(wstrb[1]), .wdata(wdata[1]), .addr_ok(addr_ok[1]), .data_ok(data_ok[1]), .rdata(rdata[1]));
    data_sram_responder #(.ADDR_WIDTH(12), .LATENCY(3), .QUEUE_DEPTH(4)) u_lat3 (
        .clk(clk), .reset(reset), .req(req[2]), .wr(wr[2]), .size(size_s), .addr(addr[2]),
        .wstrb(wstrb[2]), .wdata(wdata[2]), .addr_ok(addr_ok[2]), .data_ok(data_ok[2]), .rdata(rdata[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int i);
        case (i)
            0:       return 2;
            1:       return 8;
            default: return 3;
        endcase
    endfunction

    // Scoreboard: pop/compare responses, push expectations on accepts (next edge is cyc+1).
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (data_ok[i]) begin
                    checks++;
                    if (sb.size() == 0 || sb[0].inst != i) begin
                        failures++;
                        $display("FAIL resp_spurious inst=%0d rdata=%h expected no response", i, rdata[i]);
                    end else begin
                        e = sb.pop_front();
                        if (rdata[i] !== e.data || (cyc + 1) != e.due) begin
                            failures++;
                            $display("FAIL resp_data inst=%0d rdata=%h edge=%0d required rdata=%h edge=%0d",
                                     i, rdata[i], cyc + 1, e.data, e.due);
                        end
                    end
                end
                if (req[i] && addr_ok[i]) begin
                    e.inst = i;
                    e.due  = cyc + 1 + lat_of(i);
                    if (wr[i]) begin
                        e.data = 32'h0;
                        for (int b = 0; b < 4; b++) begin
                            if (wstrb[i][b]) mdl[i][addr[i][13:2]][8*b +: 8] = wdata[i][8*b +: 8];
                        end
                    end else begin
                        e.data = mdl[i][addr[i][13:2]];
                    end
                    sb.push_back(e);
                end
            end
            if (sb.size() > 0 && sb[0].due <= cyc + 1) begin
                checks++;
                failures++;
                $display("FAIL resp_missing inst=%0d data_ok=0 required data_ok=1 at edge %0d", sb[0].inst, sb[0].due);
                void'(sb.pop_front());
            end
        end
    end

    task automatic issue(input int i, input logic w, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d);
        bit ok = 0;
        req[i] = 1'b1; wr[i] = w; addr[i] = a; wstrb[i] = s; wdata[i] = d;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (addr_ok[i] === 1'b1) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL accept_timeout inst=%0d addr=%h addr_ok=%b required 1", i, a, addr_ok[i]);
        end
        @(posedge clk); #1;
        req[i] = 1'b0;
    endtask

    task automatic drain();
        bit done = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (sb.size() == 0) begin
                done = 1;
                break;
            end
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h100;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks += 3;
            if (addr_ok[i] !== 1'b0) begin failures++; $display("FAIL rst_addr_ok inst=%0d got=%b required 0", i, addr_ok[i]); end
            if (data_ok[i] !== 1'b0) begin failures++; $display("FAIL rst_data_ok inst=%0d got=%b required 0", i, data_ok[i]); end
            if (rdata[i] !== 32'h0)  begin failures++; $display("FAIL rst_rdata inst=%0d got=%h required 0", i, rdata[i]); end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        req[0] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks += 3;
            if (addr_ok[i] !== 1'b0) begin failures++; $display("FAIL post_rst_addr_ok inst=%0d got=%b required 0", i, addr_ok[i]); end
            if (data_ok[i] !== 1'b0) begin failures++; $display("FAIL post_rst_data_ok inst=%0d got=%b required 0", i, data_ok[i]); end
            if (rdata[i] !== 32'h0)  begin failures++; $display("FAIL post_rst_rdata inst=%0d got=%h required 0", i, rdata[i]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_word_round_trip();
        issue(0, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF);
        issue(0, 1'b0, 32'h100, 4'h0, 32'h0);
        drain();
        @(negedge clk);
        checks += 2;
        if (data_ok[0] !== 1'b0) begin failures++; $display("FAIL empty_data_ok got=%b required 0", data_ok[0]); end
        if (rdata[0] !== 32'h0)  begin failures++; $display("FAIL empty_rdata got=%h required 0", rdata[0]); end
        @(posedge clk); #1;
    endtask

    task automatic test_byte_strobes();
        issue(0, 1'b1, 32'h200, 4'hF, 32'h11223344);
        issue(0, 1'b1, 32'h200, 4'h2, 32'h0000AA00);
        issue(0, 1'b0, 32'h200, 4'h0, 32'h0);
        issue(0, 1'b1, 32'h204, 4'h0, 32'hFFFFFFFF);
        issue(0, 1'b0, 32'h0000_4203, 4'h0, 32'h0);
        drain();
    endtask

    task automatic test_raw_hazard();
        issue(0, 1'b1, 32'h300, 4'hF, 32'h55667788);
        issue(0, 1'b0, 32'h300, 4'h0, 32'h0);
        drain();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) issue(2, 1'b1, 32'(4 * k), 4'hF, 32'hA0A0_0000 + 32'(k));
        drain();
        for (int k = 0; k < 3; k++) begin
            req[2] = 1'b1; wr[2] = 1'b0; addr[2] = 32'(4 * k); wstrb[2] = 4'h0;
            @(negedge clk);
            checks++;
            if (addr_ok[2] !== 1'b1) begin failures++; $display("FAIL b2b_addr_ok k=%0d got=%b required 1", k, addr_ok[2]); end
            @(posedge clk); #1;
        end
        req[2] = 1'b0;
        drain();
    endtask

    task automatic test_full_backpressure();
        logic want;
        for (int k = 0; k < 10; k++) begin
            req[1] = 1'b1; wr[1] = 1'b1; wstrb[1] = 4'hF;
            addr[1] = 32'h500 + 32'(4 * k); wdata[1] = 32'hB000_0000 + 32'(k);
            want = (k < 4) || (k >= 9);
            @(negedge clk);
            checks++;
            if (addr_ok[1] !== want) begin failures++; $display("FAIL full_addr_ok k=%0d got=%b required %b", k, addr_ok[1], want); end
            @(posedge clk); #1;
        end
        req[1] = 1'b0;
        drain();
        issue(1, 1'b0, 32'h524, 4'h0, 32'h0);
        issue(1, 1'b0, 32'h500, 4'h0, 32'h0);
        drain();
    endtask

    task automatic test_reset_mid_flight();
        issue(0, 1'b1, 32'h400, 4'hF, 32'hCAFEF00D);
        drain();
        issue(0, 1'b0, 32'h400, 4'h0, 32'h0);
        issue(0, 1'b0, 32'h100, 4'h0, 32'h0);
        reset = 1'b1;
        req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h300;
        @(negedge clk);
        checks++;
        if (addr_ok[0] !== 1'b0) begin failures++; $display("FAIL mid_rst_addr_ok got=%b required 0", addr_ok[0]); end
        @(posedge clk); #1;
        reset = 1'b0;
        req[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks += 3;
            if (addr_ok[0] !== 1'b0) begin failures++; $display("FAIL mid_addr_ok k=%0d got=%b required 0", k, addr_ok[0]); end
            if (data_ok[0] !== 1'b0) begin failures++; $display("FAIL mid_data_ok k=%0d got=%b required 0", k, data_ok[0]); end
            if (rdata[0] !== 32'h0)  begin failures++; $display("FAIL mid_rdata k=%0d got=%h required 0", k, rdata[0]); end
            @(posedge clk); #1;
        end
        issue(0, 1'b0, 32'h400, 4'h0, 32'h0);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        size_s = 2'd2;
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0; wr[i] = 1'b0; addr[i] = 32'h0; wstrb[i] = 4'h0; wdata[i] = 32'h0;
        end
        test_reset();
        test_word_round_trip();
        test_byte_strobes();
        test_raw_hazard();
        test_back_to_back();
        test_full_backpressure();
        test_reset_mid_flight();
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
